// File: rtl/mem_pkg.sv
// Shared encodings for the memory arbiter: access sizes, FSM states, default address width.
package mem_pkg;

    localparam int ADDR_W_DEF = 9;

    localparam logic [1:0] WORD = 2'b11;
    localparam logic [1:0] HALF = 2'b01;
    localparam logic [1:0] BYTE = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } state_t;

    // Size 2'b10 has no meaning and is rejected alongside misaligned accesses.
    function automatic logic bad_access(input logic [1:0] size, input logic [1:0] addr_lo);
        return (size == 2'b10) || (size == WORD && addr_lo != 2'b00) || (size == HALF && addr_lo[0]);
    endfunction

    function automatic logic [31:0] zext_read(input logic [1:0] size, input logic [31:0] d);
        case (size)
            HALF:    return {16'h0, d[15:0]};
            BYTE:    return {24'h0, d[7:0]};
            default: return d;
        endcase
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin picker; grants are combinational, last-grant bit only moves on a taken grant.
module rr_arbiter2 (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic req_data_i,
    input  logic req_fetch_i,
    output logic gnt_data_o,
    output logic gnt_fetch_o
);

    logic last_fetch_q;

    // Ties go to whichever port was not served last; reset favours data first.
    assign gnt_data_o  = req_data_i  & (~req_fetch_i | last_fetch_q);
    assign gnt_fetch_o = req_fetch_i & (~req_data_i  | ~last_fetch_q);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_fetch_q <= 1'b1;
        end else if (en_i && (gnt_data_o || gnt_fetch_o)) begin
            last_fetch_q <= gnt_fetch_o;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one RAM port between instruction fetch and data access; min 4 cycles request-to-response.
// Requesters hold their request until the response pulse; one transaction in flight at a time.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int TIMEOUT = 15,
    parameter int ADDR_W  = ADDR_W_DEF
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              ifReq,
    input  logic [ADDR_W-1:0] ifAddr,
    output logic              ifGrant,
    output logic [31:0]       ifData,
    input  logic              dReq,
    input  logic              dWrite,
    input  logic [ADDR_W-1:0] dAddr,
    input  logic [1:0]        dSize,
    input  logic [31:0]       dDataIn,
    output logic              dDone,
    output logic [31:0]       dDataOut,
    output logic              dError,
    output logic              ramActive,
    output logic              ramReadWrite,
    output logic [ADDR_W-1:0] ramAddress,
    output logic [31:0]       ramDataIn,
    output logic [1:0]        ramDataSize,
    input  logic [31:0]       ramDataOut,
    input  logic              ramComplete
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t              state_q, state_d;
    logic                is_data_q, is_data_d;
    logic                err_q, err_d;
    logic                tmo_q, tmo_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                if_grant_q, if_grant_d;
    logic [31:0]         if_data_q, if_data_d;
    logic                d_done_q, d_done_d;
    logic [31:0]         d_dout_q, d_dout_d;
    logic                d_err_q, d_err_d;
    logic                ram_act_q, ram_act_d;
    logic                ram_rw_q, ram_rw_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic [31:0]         ram_din_q, ram_din_d;
    logic [1:0]          ram_size_q, ram_size_d;
    logic                gnt_data, gnt_fetch;
    logic                unused_if_lo;

    assign unused_if_lo = ^ifAddr[1:0];

    rr_arbiter2 u_rr (
        .clk_i       (Clk),
        .rst_i       (Reset),
        .en_i        (state_q == ST_IDLE),
        .req_data_i  (dReq),
        .req_fetch_i (ifReq),
        .gnt_data_o  (gnt_data),
        .gnt_fetch_o (gnt_fetch)
    );

    always_comb begin
        state_d    = state_q;
        is_data_d  = is_data_q;
        err_d      = err_q;
        tmo_d      = tmo_q;
        cnt_d      = cnt_q;
        rdata_d    = rdata_q;
        if_grant_d = 1'b0;
        if_data_d  = if_data_q;
        d_done_d   = 1'b0;
        d_dout_d   = d_dout_q;
        d_err_d    = 1'b0;
        ram_act_d  = ram_act_q;
        ram_rw_d   = ram_rw_q;
        ram_addr_d = ram_addr_q;
        ram_din_d  = ram_din_q;
        ram_size_d = ram_size_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                tmo_d = 1'b0;
                if (gnt_data) begin
                    is_data_d  = 1'b1;
                    ram_rw_d   = dWrite;
                    ram_addr_d = dAddr;
                    ram_din_d  = dDataIn;
                    ram_size_d = dSize;
                    err_d      = bad_access(dSize, dAddr[1:0]);
                    // Rejected accesses skip the RAM entirely.
                    state_d    = err_d ? ST_DONE : ST_ISSUE;
                end else if (gnt_fetch) begin
                    is_data_d  = 1'b0;
                    ram_rw_d   = 1'b0;
                    ram_addr_d = {ifAddr[ADDR_W-1:2], 2'b00};
                    ram_size_d = WORD;
                    err_d      = 1'b0;
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                ram_act_d = 1'b1;
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                if (ramComplete) begin
                    rdata_d   = ramDataOut;
                    ram_act_d = 1'b0;
                    state_d   = ST_DONE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    tmo_d     = 1'b1;
                    ram_act_d = 1'b0;
                    state_d   = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                if (is_data_q) begin
                    d_done_d = 1'b1;
                    d_err_d  = err_q | tmo_q;
                    if (!err_q && !tmo_q && !ram_rw_q) begin
                        d_dout_d = zext_read(ram_size_q, rdata_q);
                    end
                end else begin
                    if_grant_d = 1'b1;
                    if_data_d  = tmo_q ? 32'h0 : rdata_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= ST_IDLE;
            is_data_q  <= 1'b0;
            err_q      <= 1'b0;
            tmo_q      <= 1'b0;
            cnt_q      <= '0;
            rdata_q    <= '0;
            if_grant_q <= 1'b0;
            if_data_q  <= '0;
            d_done_q   <= 1'b0;
            d_dout_q   <= '0;
            d_err_q    <= 1'b0;
            ram_act_q  <= 1'b0;
            ram_rw_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
            ram_size_q <= '0;
        end else begin
            state_q    <= state_d;
            is_data_q  <= is_data_d;
            err_q      <= err_d;
            tmo_q      <= tmo_d;
            cnt_q      <= cnt_d;
            rdata_q    <= rdata_d;
            if_grant_q <= if_grant_d;
            if_data_q  <= if_data_d;
            d_done_q   <= d_done_d;
            d_dout_q   <= d_dout_d;
            d_err_q    <= d_err_d;
            ram_act_q  <= ram_act_d;
            ram_rw_q   <= ram_rw_d;
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
            ram_size_q <= ram_size_d;
        end
    end

    assign ifGrant      = if_grant_q;
    assign ifData       = if_data_q;
    assign dDone        = d_done_q;
    assign dDataOut     = d_dout_q;
    assign dError       = d_err_q;
    assign ramActive    = ram_act_q;
    assign ramReadWrite = ram_rw_q;
    assign ramAddress   = ram_addr_q;
    assign ramDataIn    = ram_din_q;
    assign ramDataSize  = ram_size_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a big-endian byte RAM model that can stall completion.
module tb_mem_arbiter;

    logic        Clk;
    logic        Reset;
    logic        ifReq;
    logic [8:0]  ifAddr;
    logic        ifGrant;
    logic [31:0] ifData;
    logic        dReq;
    logic        dWrite;
    logic [8:0]  dAddr;
    logic [1:0]  dSize;
    logic [31:0] dDataIn;
    logic        dDone;
    logic [31:0] dDataOut;
    logic        dError;
    logic        ramActive;
    logic        ramReadWrite;
    logic [8:0]  ramAddress;
    logic [31:0] ramDataIn;
    logic [1:0]  ramDataSize;
    logic [31:0] ramDataOut;
    logic        ramComplete;

    logic        ram_hold;
    logic [7:0]  mem [0:511];
    int          checks;
    int          errors;
    int          act_cnt;
    logic        seen;
    logic        seen_err;
    logic [31:0] seen_data;

    mem_arbiter dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .ifReq        (ifReq),
        .ifAddr       (ifAddr),
        .ifGrant      (ifGrant),
        .ifData       (ifData),
        .dReq         (dReq),
        .dWrite       (dWrite),
        .dAddr        (dAddr),
        .dSize        (dSize),
        .dDataIn      (dDataIn),
        .dDone        (dDone),
        .dDataOut     (dDataOut),
        .dError       (dError),
        .ramActive    (ramActive),
        .ramReadWrite (ramReadWrite),
        .ramAddress   (ramAddress),
        .ramDataIn    (ramDataIn),
        .ramDataSize  (ramDataSize),
        .ramDataOut   (ramDataOut),
        .ramComplete  (ramComplete)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    assign ramComplete = ramActive & ~ram_hold;

    always_comb begin
        ramDataOut = 32'h0;
        case (ramDataSize)
            2'b11:   ramDataOut = {mem[ramAddress], mem[ramAddress + 9'd1],
                                   mem[ramAddress + 9'd2], mem[ramAddress + 9'd3]};
            2'b01:   ramDataOut = {16'h0, mem[ramAddress], mem[ramAddress + 9'd1]};
            default: ramDataOut = {24'h0, mem[ramAddress]};
        endcase
    end

    always @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < 512; i++) mem[i] <= 8'h00;
            mem[2]  <= 8'h08; mem[3]  <= 8'h21;
            mem[4]  <= 8'h11; mem[5]  <= 8'h22; mem[6]  <= 8'h33; mem[7]  <= 8'h44;
            mem[8]  <= 8'h55; mem[9]  <= 8'h66; mem[10] <= 8'h77; mem[11] <= 8'h88;
        end else if (ramActive && ramComplete && ramReadWrite) begin
            case (ramDataSize)
                2'b11: begin
                    mem[ramAddress]         <= ramDataIn[31:24];
                    mem[ramAddress + 9'd1]  <= ramDataIn[23:16];
                    mem[ramAddress + 9'd2]  <= ramDataIn[15:8];
                    mem[ramAddress + 9'd3]  <= ramDataIn[7:0];
                end
                2'b01: begin
                    mem[ramAddress]         <= ramDataIn[15:8];
                    mem[ramAddress + 9'd1]  <= ramDataIn[7:0];
                end
                default: mem[ramAddress]    <= ramDataIn[7:0];
            endcase
        end
    end

    task automatic nclk(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Watches one response pulse for up to 40 cycles, counting ramActive-high cycles meanwhile.
    task automatic watch(input logic want_data);
        act_cnt   = 0;
        seen      = 1'b0;
        seen_err  = 1'b0;
        seen_data = 32'h0;
        for (int i = 0; i < 40; i++) begin
            nclk(1);
            if (ramActive) act_cnt++;
            if (want_data ? dDone : ifGrant) begin
                seen      = 1'b1;
                seen_err  = dError;
                seen_data = want_data ? dDataOut : ifData;
                break;
            end
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        Reset    = 1'b1;
        ram_hold = 1'b0;
        ifReq    = 1'b0;
        ifAddr   = 9'h0;
        dReq     = 1'b0;
        dWrite   = 1'b0;
        dAddr    = 9'h0;
        dSize    = 2'b11;
        dDataIn  = 32'h0;
        nclk(3);
        chk("rst_ramActive", {31'h0, ramActive}, 32'h0);
        chk("rst_ifGrant", {31'h0, ifGrant}, 32'h0);
        chk("rst_dDone", {31'h0, dDone}, 32'h0);
        chk("rst_dError", {31'h0, dError}, 32'h0);
        chk("rst_ifData", ifData, 32'h0);
        chk("rst_dDataOut", dDataOut, 32'h0);
        chk("rst_ramAddress", {23'h0, ramAddress}, 32'h0);
        Reset = 1'b0;
        nclk(1);

        // Both pending at first IDLE: data, fetch, data, fetch.
        ifReq = 1'b1; ifAddr = 9'h008;
        dReq  = 1'b1; dWrite = 1'b0; dAddr = 9'h004; dSize = 2'b11;
        nclk(4);
        chk("rr1_dDone", {31'h0, dDone}, 32'h1);
        chk("rr1_ifGrant", {31'h0, ifGrant}, 32'h0);
        chk("rr1_dDataOut", dDataOut, 32'h11223344);
        nclk(4);
        chk("rr2_ifGrant", {31'h0, ifGrant}, 32'h1);
        chk("rr2_dDone", {31'h0, dDone}, 32'h0);
        chk("rr2_ifData", ifData, 32'h55667788);
        nclk(4);
        chk("rr3_dDone", {31'h0, dDone}, 32'h1);
        nclk(4);
        chk("rr4_ifGrant", {31'h0, ifGrant}, 32'h1);
        ifReq = 1'b0; dReq = 1'b0;
        nclk(2);
        chk("rr_idle_ramActive", {31'h0, ramActive}, 32'h0);

        // Fetch of word 0 at minimum latency.
        ifReq = 1'b1; ifAddr = 9'h000;
        nclk(1);
        chk("f_issue_ramActive", {31'h0, ramActive}, 32'h0);
        nclk(1);
        chk("f_wait_ramActive", {31'h0, ramActive}, 32'h1);
        chk("f_ramReadWrite", {31'h0, ramReadWrite}, 32'h0);
        chk("f_ramAddress", {23'h0, ramAddress}, 32'h0);
        nclk(1);
        chk("f_done_ramActive", {31'h0, ramActive}, 32'h0);
        chk("f_early_ifGrant", {31'h0, ifGrant}, 32'h0);
        nclk(1);
        chk("f_ifGrant", {31'h0, ifGrant}, 32'h1);
        chk("f_ifData", ifData, 32'h00000821);
        ifReq = 1'b0;
        nclk(1);
        chk("f_pulse_end", {31'h0, ifGrant}, 32'h0);

        // Word write then half and byte reads of it.
        dReq = 1'b1; dWrite = 1'b1; dAddr = 9'h010; dSize = 2'b11; dDataIn = 32'hDEADBEEF;
        nclk(2);
        chk("w_ramActive", {31'h0, ramActive}, 32'h1);
        chk("w_ramReadWrite", {31'h0, ramReadWrite}, 32'h1);
        chk("w_ramDataIn", ramDataIn, 32'hDEADBEEF);
        chk("w_ramAddress", {23'h0, ramAddress}, 32'h010);
        nclk(2);
        chk("w_dDone", {31'h0, dDone}, 32'h1);
        chk("w_dError", {31'h0, dError}, 32'h0);
        dReq = 1'b0;
        nclk(1);
        dReq = 1'b1; dWrite = 1'b0; dAddr = 9'h012; dSize = 2'b01; dDataIn = 32'h0;
        nclk(2);
        chk("h_ramDataSize", {30'h0, ramDataSize}, 32'h1);
        nclk(2);
        chk("h_dDone", {31'h0, dDone}, 32'h1);
        chk("h_dDataOut", dDataOut, 32'h0000BEEF);
        dReq = 1'b0;
        nclk(1);
        dReq = 1'b1; dAddr = 9'h013; dSize = 2'b00;
        nclk(4);
        chk("b_dDone", {31'h0, dDone}, 32'h1);
        chk("b_dDataOut", dDataOut, 32'h000000EF);
        dReq = 1'b0;
        nclk(1);

        // Misaligned word and illegal size: error after two edges, RAM untouched.
        dReq = 1'b1; dAddr = 9'h005; dSize = 2'b11;
        nclk(1);
        chk("mis_ramActive0", {31'h0, ramActive}, 32'h0);
        chk("mis_early_dDone", {31'h0, dDone}, 32'h0);
        nclk(1);
        chk("mis_dDone", {31'h0, dDone}, 32'h1);
        chk("mis_dError", {31'h0, dError}, 32'h1);
        chk("mis_ramActive1", {31'h0, ramActive}, 32'h0);
        dReq = 1'b0;
        nclk(1);
        dReq = 1'b1; dAddr = 9'h004; dSize = 2'b10;
        nclk(1);
        chk("ill_ramActive0", {31'h0, ramActive}, 32'h0);
        nclk(1);
        chk("ill_dDone", {31'h0, dDone}, 32'h1);
        chk("ill_dError", {31'h0, dError}, 32'h1);
        chk("ill_ramActive1", {31'h0, ramActive}, 32'h0);
        dReq = 1'b0;
        nclk(1);

        // RAM never completes: abort after TIMEOUT cycles of ramActive.
        ram_hold = 1'b1;
        dReq = 1'b1; dAddr = 9'h000; dSize = 2'b11;
        watch(1'b1);
        chk("tmo_d_seen", {31'h0, seen}, 32'h1);
        chk("tmo_d_active_cycles", act_cnt, 32'd15);
        chk("tmo_d_dError", {31'h0, seen_err}, 32'h1);
        dReq = 1'b0;
        nclk(1);
        ifReq = 1'b1; ifAddr = 9'h004;
        watch(1'b0);
        chk("tmo_f_seen", {31'h0, seen}, 32'h1);
        chk("tmo_f_active_cycles", act_cnt, 32'd15);
        chk("tmo_f_ifData", seen_data, 32'h0);
        ifReq = 1'b0;
        nclk(1);

        // Reset while waiting on the RAM.
        dReq = 1'b1; dAddr = 9'h004; dSize = 2'b11;
        nclk(3);
        chk("rw_ramActive_pre", {31'h0, ramActive}, 32'h1);
        Reset = 1'b1; dReq = 1'b0;
        nclk(1);
        chk("rw_ramActive", {31'h0, ramActive}, 32'h0);
        chk("rw_dDataOut", dDataOut, 32'h0);
        Reset = 1'b0; ram_hold = 1'b0;
        nclk(2);
        chk("rw_no_dDone", {31'h0, dDone}, 32'h0);
        chk("rw_no_ifGrant", {31'h0, ifGrant}, 32'h0);
        ifReq = 1'b1; ifAddr = 9'h003;
        nclk(2);
        chk("rw_f_ramActive", {31'h0, ramActive}, 32'h1);
        chk("rw_f_ramAddress", {23'h0, ramAddress}, 32'h0);
        nclk(2);
        chk("rw_f_ifGrant", {31'h0, ifGrant}, 32'h1);
        chk("rw_f_ifData", ifData, 32'h00000821);
        ifReq = 1'b0;
        nclk(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
